// File: rtl/bcd_countdown_timer_pkg.sv
// rtl/bcd_countdown_timer_pkg.sv - shared states, BCD limits and preset clamp helpers
package bcd_countdown_timer_pkg;

  // Timer state, 2-bit encoded
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [3:0] BCD_UNIT_MAX = 4'd9;
  localparam logic [3:0] BCD_TENS_MAX = 4'd5;

  // Saturate one BCD digit to its legal maximum
  function automatic logic [3:0] bcd_clamp(input logic [3:0] d, input logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction

  // Clamp a packed tens/units pair of a mod-60 field
  function automatic logic [7:0] clamp_pair(input logic [7:0] v);
    return {bcd_clamp(v[7:4], BCD_TENS_MAX), bcd_clamp(v[3:0], BCD_UNIT_MAX)};
  endfunction

endpackage

// File: rtl/bcd_countdown_timer_bcd_down_digit.sv
// rtl/bcd_countdown_timer_bcd_down_digit.sv - mod-(MAX+1) BCD down-counting digit
module bcd_down_digit
  import bcd_countdown_timer_pkg::*;
#(
  parameter logic [3:0] MAX = BCD_UNIT_MAX
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] q,
  output logic       borrow
);

  logic [3:0] q_q;
  logic [3:0] q_d;

  // Next digit value: load wins, otherwise decrement with wrap to MAX
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (en) begin
      q_d = (q_q == 4'd0) ? MAX : (q_q - 4'd1);
    end
  end

  // Digit register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;
  // A decrement from zero wraps this digit and must take one from the next digit up
  assign borrow = en && (q_q == 4'd0);

endmodule

// File: rtl/bcd_countdown_timer.sv
// rtl/bcd_countdown_timer.sv - MM:SS packed-BCD countdown timer with alarm
module bcd_countdown_timer
  import bcd_countdown_timer_pkg::*;
#(
  parameter int unsigned ALARM_CYCLES = 8
) (
  input  logic       clk,
  input  logic       cr,
  input  logic       tick,
  input  logic       load,
  input  logic [7:0] load_min,
  input  logic [7:0] load_sec,
  input  logic       start,
  input  logic       pause,
  output logic [7:0] min,
  output logic [7:0] sec,
  output logic       borrow_sig,
  output logic       running,
  output logic       done
);

  localparam int AW = $clog2(ALARM_CYCLES + 1);
  localparam logic [AW-1:0] ALARM_INIT = AW'(ALARM_CYCLES);

  state_e        state_q, state_d;
  logic [AW-1:0] alarm_q, alarm_d;
  logic          borrow_sig_q, borrow_sig_d;
  logic          running_q, running_d;
  logic          done_q, done_d;

  logic [7:0] min_clamped;
  logic [7:0] sec_clamped;
  logic       digit_load;
  logic       cnt_en;
  logic [3:0] su_q, st_q, mu_q, mt_q;
  logic       su_borrow, st_borrow, mu_borrow, mt_borrow;
  logic       value_zero;
  logic       expire;

  assign min_clamped = clamp_pair(load_min);
  assign sec_clamped = clamp_pair(load_sec);

  // The preset is only taken while the counter is not running
  assign digit_load = load && (state_q != ST_RUN);
  assign cnt_en     = (state_q == ST_RUN) && tick;

  bcd_down_digit #(.MAX(BCD_UNIT_MAX)) u_sec_units (
    .clk      (clk),
    .rst_n    (cr),
    .en       (cnt_en),
    .load     (digit_load),
    .load_val (sec_clamped[3:0]),
    .q        (su_q),
    .borrow   (su_borrow)
  );

  bcd_down_digit #(.MAX(BCD_TENS_MAX)) u_sec_tens (
    .clk      (clk),
    .rst_n    (cr),
    .en       (su_borrow),
    .load     (digit_load),
    .load_val (sec_clamped[7:4]),
    .q        (st_q),
    .borrow   (st_borrow)
  );

  bcd_down_digit #(.MAX(BCD_UNIT_MAX)) u_min_units (
    .clk      (clk),
    .rst_n    (cr),
    .en       (st_borrow),
    .load     (digit_load),
    .load_val (min_clamped[3:0]),
    .q        (mu_q),
    .borrow   (mu_borrow)
  );

  bcd_down_digit #(.MAX(BCD_TENS_MAX)) u_min_tens (
    .clk      (clk),
    .rst_n    (cr),
    .en       (mu_borrow),
    .load     (digit_load),
    .load_val (min_clamped[7:4]),
    .q        (mt_q),
    .borrow   (mt_borrow)
  );

  assign min = {mt_q, mu_q};
  assign sec = {st_q, su_q};

  assign value_zero = (min == 8'h00) && (sec == 8'h00);
  // Expiry is the tick that takes 00:01 to 00:00; a minute-tens borrow would mean
  // counting below 00:00, which start never allows, so it is treated as expiry too.
  assign expire = (cnt_en && (min == 8'h00) && (sec == 8'h01)) || mt_borrow;

  // State, alarm counter and registered status flags
  always_comb begin
    state_d      = state_q;
    alarm_d      = alarm_q;
    // Seconds tens borrowing means sec was 00 and becomes 59 on this edge
    borrow_sig_d = st_borrow;
    case (state_q)
      ST_IDLE, ST_PAUSE: begin
        if (load) begin
          state_d = ST_IDLE;
        end else if (!pause && start && !value_zero) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (expire) begin
          state_d = ST_DONE;
          alarm_d = ALARM_INIT;
        end else if (pause) begin
          state_d = ST_PAUSE;
        end
      end
      ST_DONE: begin
        if (load) begin
          state_d = ST_IDLE;
          alarm_d = '0;
        end else if (alarm_q <= AW'(1)) begin
          state_d = ST_IDLE;
          alarm_d = '0;
        end else begin
          alarm_d = alarm_q - AW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        alarm_d = '0;
      end
    endcase
    running_d = (state_d == ST_RUN);
    done_d    = (state_d == ST_DONE);
  end

  // Control registers, cleared asynchronously by cr
  always_ff @(posedge clk or negedge cr) begin
    if (!cr) begin
      state_q      <= ST_IDLE;
      alarm_q      <= '0;
      borrow_sig_q <= 1'b0;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      alarm_q      <= alarm_d;
      borrow_sig_q <= borrow_sig_d;
      running_q    <= running_d;
      done_q       <= done_d;
    end
  end

  assign borrow_sig = borrow_sig_q;
  assign running    = running_q;
  assign done       = done_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb/tb_bcd_countdown_timer.sv - randomized self-checking bench for bcd_countdown_timer
module tb_bcd_countdown_timer;

  localparam int ALARM = 8;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic       clk;
  logic       cr;
  logic       tick;
  logic       load;
  logic [7:0] load_min;
  logic [7:0] load_sec;
  logic       start;
  logic       pause;
  logic [7:0] min;
  logic [7:0] sec;
  logic       borrow_sig;
  logic       running;
  logic       done;

  int n_cmp;
  int n_bad;

  // reference model: remaining time in whole seconds plus a mode
  int m_secs;
  int m_mode;
  int m_alarm;
  int m_borrow;

  bcd_countdown_timer #(.ALARM_CYCLES(ALARM)) dut (
    .clk        (clk),
    .cr         (cr),
    .tick       (tick),
    .load       (load),
    .load_min   (load_min),
    .load_sec   (load_sec),
    .start      (start),
    .pause      (pause),
    .min        (min),
    .sec        (sec),
    .borrow_sig (borrow_sig),
    .running    (running),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic int lim(input logic [3:0] d, input int mx);
    return (int'(d) > mx) ? mx : int'(d);
  endfunction

  function automatic int preset_secs(input logic [7:0] lm, input logic [7:0] ls);
    int mm;
    int ss;
    mm = lim(lm[7:4], 5) * 10 + lim(lm[3:0], 9);
    ss = lim(ls[7:4], 5) * 10 + lim(ls[3:0], 9);
    return mm * 60 + ss;
  endfunction

  task automatic model_reset();
    m_secs   = 0;
    m_mode   = M_IDLE;
    m_alarm  = 0;
    m_borrow = 0;
  endtask

  task automatic model_step(input logic l, input logic [7:0] lm, input logic [7:0] ls,
                            input logic s, input logic p, input logic t);
    m_borrow = 0;
    if (m_mode == M_RUN) begin
      if (t) begin
        if (m_secs % 60 == 0) m_borrow = 1;
        m_secs = m_secs - 1;
        if (m_secs == 0) begin
          m_mode  = M_DONE;
          m_alarm = ALARM;
        end else if (p) begin
          m_mode = M_PAUSE;
        end
      end else if (p) begin
        m_mode = M_PAUSE;
      end
    end else if (l) begin
      m_secs  = preset_secs(lm, ls);
      m_mode  = M_IDLE;
      m_alarm = 0;
    end else if (m_mode == M_DONE) begin
      m_alarm = m_alarm - 1;
      if (m_alarm == 0) m_mode = M_IDLE;
    end else if (!p && s && m_secs != 0) begin
      m_mode = M_RUN;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".min"}, 16'(min), 16'(to_bcd(m_secs / 60)));
    check({tag, ".sec"}, 16'(sec), 16'(to_bcd(m_secs % 60)));
    check({tag, ".borrow"}, 16'(borrow_sig), 16'(m_borrow));
    check({tag, ".running"}, 16'(running), 16'(m_mode == M_RUN));
    check({tag, ".done"}, 16'(done), 16'(m_mode == M_DONE));
  endtask

  // drive one clock of inputs, advance model, sample after the edge
  task automatic cycle(input logic l, input logic [7:0] lm, input logic [7:0] ls,
                       input logic s, input logic p, input logic t);
    @(negedge clk);
    load = l; load_min = lm; load_sec = ls; start = s; pause = p; tick = t;
    model_step(l, lm, ls, s, p, t);
    @(posedge clk);
    #1;
    compare_all("cyc");
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic async_clear();
    @(negedge clk);
    cr = 1'b0;
    #1;
    model_reset();
    compare_all("clr");
    @(negedge clk);
    cr = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cr = 1'b0;
    tick = 1'b0; load = 1'b0; load_min = 8'h00; load_sec = 8'h00;
    start = 1'b0; pause = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all("reset");
    @(negedge clk);
    cr = 1'b1;

    // clear mid-RUN at 05:30
    cycle(1'b1, 8'h05, 8'h30, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    check("run_0530", 16'(running), 16'd1);
    async_clear();
    check("clr_min", 16'(min), 16'h00);
    check("clr_run", 16'(running), 16'd0);

    // 02:00 -> 01:59 with one borrow pulse
    cycle(1'b1, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    tick_cycles(1);
    check("d0200_min", 16'(min), 16'h01);
    check("d0200_sec", 16'(sec), 16'h59);
    check("d0200_borrow", 16'(borrow_sig), 16'd1);
    idle_cycles(1);
    check("d0200_borrow_end", 16'(borrow_sig), 16'd0);
    check("d0200_running", 16'(running), 16'd1);
    cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);

    // 00:03 -> expiry, done for ALARM clocks
    cycle(1'b1, 8'h00, 8'h03, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    tick_cycles(3);
    check("d0003_done", 16'(done), 16'd1);
    check("d0003_run", 16'(running), 16'd0);
    idle_cycles(ALARM - 1);
    check("d0003_done_last", 16'(done), 16'd1);
    idle_cycles(1);
    check("d0003_done_off", 16'(done), 16'd0);

    // 10:00, pause together with a tick
    cycle(1'b1, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    tick_cycles(3);
    cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    check("d1000_min", 16'(min), 16'h09);
    check("d1000_sec", 16'(sec), 16'h56);
    check("d1000_paused", 16'(running), 16'd0);
    tick_cycles(3);
    check("d1000_hold", 16'(sec), 16'h56);
    cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    check("d1000_resume", 16'(running), 16'd1);
    tick_cycles(1);
    check("d1000_sec2", 16'(sec), 16'h55);

    // clamp, load during RUN ignored, start at 00:00 ignored
    cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 8'hAF, 8'h7C, 1'b0, 1'b0, 1'b0);
    check("clamp_min", 16'(min), 16'h59);
    check("clamp_sec", 16'(sec), 16'h59);
    cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
    check("run_load_ign", 16'(min), 16'h59);
    cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    check("start_zero_ign", 16'(running), 16'd0);

    // load+start together, then load aborting DONE
    cycle(1'b1, 8'h12, 8'h34, 1'b1, 1'b0, 1'b0);
    check("ldst_min", 16'(min), 16'h12);
    check("ldst_run", 16'(running), 16'd0);
    cycle(1'b1, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    tick_cycles(1);
    check("done_set", 16'(done), 16'd1);
    idle_cycles(2);
    cycle(1'b1, 8'h00, 8'h05, 1'b0, 1'b0, 1'b0);
    check("done_abort", 16'(done), 16'd0);
    check("done_abort_sec", 16'(sec), 16'h05);

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      logic       l, s, p, t;
      logic [7:0] lm, ls;
      if ($urandom_range(999) == 0) begin
        async_clear();
      end else begin
        l  = ($urandom_range(99) < 3);
        lm = ($urandom_range(1) == 0) ? 8'h00 : 8'($urandom);
        ls = 8'($urandom);
        s  = ($urandom_range(99) < 20);
        p  = ($urandom_range(99) < 3);
        t  = ($urandom_range(99) < 40);
        cycle(l, lm, ls, s, p, t);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
